chain_test_sequencer: RTL and testbench

Self-checking sequencer for the inverter delay-chain test structure. It drives the chain's data input (`din`) and mode select (`test`), then checks the registered chain output (`dout`) against the bit it expects. It runs a bypass phase and then a chain phase, and reports a mismatch count for each phase plus an overall pass flag. It sits between the tile I/O and one `testchain` instance and replaces manual pin toggling.

---
 rtl/chain_seq_pkg.sv | 27 ++
 rtl/chain_seq_lfsr.sv | 45 ++++
 rtl/chain_test_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_chain_test_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/chain_seq_pkg.sv
// ============================================================================
//  Module   : chain_seq_pkg
//  Purpose  : Shared state encoding, LFSR tap mask and fail_idx width for the
//             inverter delay-chain test sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chain_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BYP_RUN   = 3'd1,
        S_BYP_FLUSH = 3'd2,
        S_CHN_RUN   = 3'd3,
        S_CHN_FLUSH = 3'd4,
        S_DONE      = 3'd5
    } chain_state_e;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    localparam int FAIL_IDX_W = 16;

endpackage

`default_nettype wire

// File: rtl/chain_seq_lfsr.sv
// ============================================================================
//  Module   : chain_seq_lfsr
//  Purpose  : 16-bit Fibonacci LFSR with synchronous load and shift enable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chain_seq_lfsr
    import chain_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        shift,
    output logic        lfsr_bit
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        w_feedback;

    always_comb begin
        w_feedback = ^(lfsr_q & LFSR_TAP_MASK);
        lfsr_d     = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (shift) begin
            lfsr_d = {w_feedback, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_bit = lfsr_q[0];

endmodule

`default_nettype wire

// File: rtl/chain_test_sequencer.sv
// ============================================================================
//  Module   : chain_test_sequencer
//  Purpose  : Drives a bypass phase then a chain phase into a testchain and
//             counts mismatches on its registered output per phase.
//             Optional macro CHAINSEQ_FAIL_IDX_EN enables first-failure index.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chain_test_sequencer
    import chain_seq_pkg::*;
#(
    parameter int          N_TRIALS = 16,
    parameter int          LAT      = 2,
    parameter int          COUNT_W  = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dout,
    output logic                  din,
    output logic                  test,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [COUNT_W-1:0]    err_bypass,
    output logic [COUNT_W-1:0]    err_chain,
    output logic [FAIL_IDX_W-1:0] fail_idx
);

    localparam int TRIAL_W = 17;
    localparam logic [2:0] ST_IDLE      = S_IDLE;
    localparam logic [2:0] ST_BYP_RUN   = S_BYP_RUN;
    localparam logic [2:0] ST_BYP_FLUSH = S_BYP_FLUSH;
    localparam logic [2:0] ST_CHN_RUN   = S_CHN_RUN;
    localparam logic [2:0] ST_CHN_FLUSH = S_CHN_FLUSH;
    localparam logic [2:0] ST_DONE      = S_DONE;

    localparam logic [TRIAL_W-1:0] c_run_last   = TRIAL_W'(N_TRIALS - 1);
    localparam logic [TRIAL_W-1:0] c_flush_last = TRIAL_W'(N_TRIALS + LAT - 1);
    localparam logic [TRIAL_W-1:0] c_lat        = TRIAL_W'(LAT);
    localparam logic [COUNT_W-1:0] c_err_max    = '1;

    logic [2:0]         state_q,   state_d;
    logic [TRIAL_W-1:0] trial_q,   trial_d;
    logic [LAT-1:0]     exp_q,     exp_d;
    logic [LAT-1:0]     vld_q,     vld_d;
    logic [COUNT_W-1:0] err_byp_q, err_byp_d;
    logic [COUNT_W-1:0] err_chn_q, err_chn_d;
    logic               din_q,  din_d;
    logic               test_q, test_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic w_accept, w_run, w_active, w_chain_ph, w_phase_end, w_mismatch;
    logic w_lfsr_load, w_lfsr_bit;

    always_comb begin
        w_accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        w_run       = (state_q == ST_BYP_RUN) || (state_q == ST_CHN_RUN);
        w_active    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        w_chain_ph  = (state_q == ST_CHN_RUN) || (state_q == ST_CHN_FLUSH);
        w_phase_end = ((state_q == ST_BYP_FLUSH) || (state_q == ST_CHN_FLUSH))
                      && (trial_q == c_flush_last);
        w_mismatch  = vld_q[LAT-1] && (dout != exp_q[LAT-1]);
        // Second phase replays the exact same pattern as the first.
        w_lfsr_load = w_accept || ((state_q == ST_BYP_FLUSH) && w_phase_end);

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (w_accept)                state_d = ST_BYP_RUN;
            ST_BYP_RUN:       if (trial_q == c_run_last)   state_d = ST_BYP_FLUSH;
            ST_BYP_FLUSH:     if (w_phase_end)             state_d = ST_CHN_RUN;
            ST_CHN_RUN:       if (trial_q == c_run_last)   state_d = ST_CHN_FLUSH;
            ST_CHN_FLUSH:     if (w_phase_end)             state_d = ST_DONE;
            default:                                       state_d = ST_IDLE;
        endcase

        if (w_accept || w_phase_end) begin
            trial_d = '0;
        end else if (w_active) begin
            trial_d = trial_q + TRIAL_W'(1);
        end else begin
            trial_d = trial_q;
        end

        exp_d    = '0;
        vld_d    = '0;
        exp_d[0] = w_lfsr_bit;
        vld_d[0] = w_run;
        for (int i = 1; i < LAT; i++) begin
            exp_d[i] = exp_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
        if (w_accept || w_phase_end) begin
            vld_d = '0;
        end

        err_byp_d = err_byp_q;
        err_chn_d = err_chn_q;
        if (w_accept) begin
            err_byp_d = '0;
            err_chn_d = '0;
        end else if (w_mismatch) begin
            if (w_chain_ph) begin
                if (err_chn_q != c_err_max) err_chn_d = err_chn_q + COUNT_W'(1);
            end else begin
                if (err_byp_q != c_err_max) err_byp_d = err_byp_q + COUNT_W'(1);
            end
        end

        din_d  = w_run ? w_lfsr_bit : din_q;
        test_d = w_chain_ph;
        busy_d = w_active;
        done_d = (state_q == ST_DONE) && !w_accept;
        pass_d = done_d && (err_byp_q == '0) && (err_chn_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            trial_q   <= '0;
            exp_q     <= '0;
            vld_q     <= '0;
            err_byp_q <= '0;
            err_chn_q <= '0;
            din_q     <= 1'b0;
            test_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trial_q   <= trial_d;
            exp_q     <= exp_d;
            vld_q     <= vld_d;
            err_byp_q <= err_byp_d;
            err_chn_q <= err_chn_d;
            din_q     <= din_d;
            test_q    <= test_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    chain_seq_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_lfsr_load),
        .seed     (SEED),
        .shift    (w_run),
        .lfsr_bit (w_lfsr_bit)
    );

`ifdef CHAINSEQ_FAIL_IDX_EN
    logic [FAIL_IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic                  fail_seen_q, fail_seen_d;
    logic [14:0]           w_head_idx;

    // The pipeline head was driven LAT cycles before the current trial count.
    always_comb begin
        w_head_idx  = 15'(trial_q - c_lat);
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        if (w_accept) begin
            fail_idx_d  = '0;
            fail_seen_d = 1'b0;
        end else if (w_mismatch && !fail_seen_q) begin
            fail_idx_d  = {w_chain_ph, w_head_idx};
            fail_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign fail_idx = fail_idx_q;
`else
    assign fail_idx = '0;
`endif

    assign din        = din_q;
    assign test       = test_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_bypass = err_byp_q;
    assign err_chain  = err_chn_q;

endmodule

`default_nettype wire

// File: tb/tb_chain_test_sequencer.sv
// ============================================================================
//  Module   : tb_chain_test_sequencer
//  Purpose  : Scoreboard bench for chain_test_sequencer with a modelled chain
//             (good / chain-inverting / stuck-at-0) and a COUNT_W=3 instance.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chain_test_sequencer;

    localparam int          N         = 16;
    localparam int          LAT       = 2;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          DONE_EDGE = 2 * (N + LAT) + 1;
    localparam int          MODE_GOOD    = 0;
    localparam int          MODE_INV_CHN = 1;
    localparam int          MODE_STUCK0  = 2;

    typedef struct {
        logic [31:0] eb;
        logic [31:0] ec;
        logic [31:0] pass;
        logic [31:0] fidx;
        logic [31:0] first_bit;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    int          fault_mode = MODE_GOOD;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];

    logic        dout_a = 1'b0;
    logic        din_a, test_a, busy_a, done_a, pass_a;
    logic [7:0]  eb_a, ec_a;
    logic [15:0] fi_a;

    logic        dout_b = 1'b0;
    logic        din_b, test_b, busy_b, done_b, pass_b;
    logic [2:0]  eb_b, ec_b;
    logic [15:0] fi_b;

    always #5 clk = ~clk;

    chain_test_sequencer #(.N_TRIALS(N), .LAT(LAT), .COUNT_W(8), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .dout(dout_a),
        .din(din_a), .test(test_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_bypass(eb_a), .err_chain(ec_a), .fail_idx(fi_a)
    );

    chain_test_sequencer #(.N_TRIALS(N), .LAT(LAT), .COUNT_W(3), .SEED(SEED)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .dout(dout_b),
        .din(din_b), .test(test_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_bypass(eb_b), .err_chain(ec_b), .fail_idx(fi_b)
    );

    // One chain flop after the sequencer's registered din gives LAT=2.
    always @(posedge clk) begin
        case (fault_mode)
            MODE_INV_CHN: dout_a <= test_a ? ~din_a : din_a;
            MODE_STUCK0:  dout_a <= 1'b0;
            default:      dout_a <= din_a;
        endcase
        dout_b <= ~din_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input int mode);
        exp_t        e;
        logic [15:0] l;
        logic [N-1:0] bits;
        logic        fb, b, obs;
        bit          seen;
        l = SEED;
        for (int i = 0; i < N; i++) begin
            bits[i] = l[0];
            fb      = l[0] ^ l[2] ^ l[3] ^ l[5];
            l       = {fb, l[15:1]};
        end
        e.eb = 0; e.ec = 0; e.fidx = 0; seen = 0;
        e.first_bit = {31'd0, bits[0]};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                b = bits[i];
                case (mode)
                    MODE_INV_CHN: obs = (p == 1) ? ~b : b;
                    MODE_STUCK0:  obs = 1'b0;
                    default:      obs = b;
                endcase
                if (obs != b) begin
                    if (p == 0) begin if (e.eb < 255) e.eb++; end
                    else        begin if (e.ec < 255) e.ec++; end
                    if (!seen) begin
                        seen   = 1;
                        e.fidx = ((p == 1) ? 32'h8000 : 32'h0) | 32'(i);
                    end
                end
            end
        end
        e.pass = (e.eb == 0 && e.ec == 0) ? 32'd1 : 32'd0;
`ifndef CHAINSEQ_FAIL_IDX_EN
        e.fidx = 0;
`endif
        return e;
    endfunction

    task automatic check_reset(input string pfx);
        chk({pfx, "_din"},  din_a,  0);
        chk({pfx, "_test"}, test_a, 0);
        chk({pfx, "_busy"}, busy_a, 0);
        chk({pfx, "_done"}, done_a, 0);
        chk({pfx, "_pass"}, pass_a, 0);
        chk({pfx, "_eb"},   eb_a,   0);
        chk({pfx, "_ec"},   ec_a,   0);
        chk({pfx, "_fidx"}, fi_a,   0);
        chk({pfx, "_sat_eb"}, eb_b, 0);
    endtask

    task automatic run(input int mode, input bit restart, input bit do_rst);
        exp_t e, g;
        int   edge_n;
        bit   fin;
        fault_mode = mode;
        e = model(mode);
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        edge_n = 0;
        fin    = 0;
        while (!fin && edge_n <= DONE_EDGE + 20) begin
            @(negedge clk);
            start = restart && (edge_n == 9);
            if (edge_n == 0) begin
                chk("busy_e0", busy_a, 0);
                chk("done_e0", done_a, 0);
            end
            if (edge_n == 1) begin
                chk("busy_e1", busy_a, 1);
                chk("din_e1",  din_a,  e.first_bit);
                chk("test_e1", test_a, 0);
            end
            if (edge_n == N + LAT + 1) chk("test_chn", test_a, 1);
            if (do_rst && edge_n == 20) rst = 1'b1;
            if (do_rst && edge_n == 21) begin
                check_reset("mid");
                rst = 1'b0;
                g   = sb.pop_back();
                fin = 1;
            end else if (done_a) begin
                chk("done_edge", edge_n, DONE_EDGE);
                g = sb.pop_front();
                chk("err_bypass", eb_a,   g.eb);
                chk("err_chain",  ec_a,   g.ec);
                chk("pass",       pass_a, g.pass);
                chk("fail_idx",   fi_a,   g.fidx);
                chk("sat_eb",     eb_b,   7);
                chk("sat_ec",     ec_b,   7);
                chk("sat_pass",   pass_b, 0);
                repeat (3) @(negedge clk);
                chk("done_hold",  done_a, 1);
                chk("eb_hold",    eb_a,   g.eb);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk);
                edge_n++;
            end
        end
        if (!fin) begin
            chk("done_timeout", 0, 1);
            g = sb.pop_front();
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        run(MODE_GOOD,    0, 0);
        run(MODE_INV_CHN, 0, 0);
        run(MODE_STUCK0,  0, 0);
        run(MODE_GOOD,    1, 0);
        run(MODE_INV_CHN, 0, 1);
        run(MODE_GOOD,    0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
